// File: rtl/ndma_wr_feeder.sv
// ndma_wr_feeder: buffers read-side data words in a small FIFO and feeds them,
// one write at a time, to the DMA OBI write manager with incrementing
// destination addresses. Counts write responses and pulses done at the end.
//
// Handshakes:
//  - Read side: a word moves when rd_valid_i & rd_ready_o are both high on a
//    rising edge. rd_ready_o depends only on registered state, never on
//    rd_valid_i.
//  - Write side: wr_req_o is a single-cycle request; the manager answers with
//    exactly one wr_ack_i pulse. Only one write is outstanding at a time, and
//    no request is raised in a cycle where wr_ack_i is high.
module ndma_wr_feeder #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [AW-1:0]            dst_addr_i,
  input  logic [15:0]              len_i,
  output logic                     busy_o,
  output logic                     done_o,
  input  logic                     rd_valid_i,
  input  logic [DW-1:0]            rd_data_i,
  output logic                     rd_ready_o,
  output logic                     wr_req_o,
  output logic [AW-1:0]            wr_addr_o,
  output logic [DW-1:0]            wr_data_o,
  input  logic                     wr_ack_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [1:0]               state_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   cur_addr_q;
  logic [15:0]     len_q;
  logic [15:0]     push_cnt_q;
  logic [15:0]     ack_cnt_q;
  logic            outstanding_q;
  logic            zero_done_q;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;

  logic start_go;
  logic start_zero;
  logic full;
  logic push;
  logic pop;
  logic ack_take;

  // Next-state logic; a zero-length start only produces a done pulse.
  always_comb begin
    state_d    = state_q;
    start_go   = 1'b0;
    start_zero = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != 16'd0) begin
            start_go = 1'b1;
            state_d  = RUN;
          end else begin
            start_zero = 1'b1;
          end
        end
      end
      RUN: begin
        if (ack_take && (ack_cnt_q == len_q - 16'd1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath strobes and outputs, all derived from registered state.
  always_comb begin
    full       = (level_q == LW'(DEPTH));
    rd_ready_o = (state_q == RUN) && !full && (push_cnt_q < len_q);
    push       = rd_valid_i && rd_ready_o;
    pop        = (state_q == RUN) && (level_q != '0) && !outstanding_q && !wr_ack_i;
    ack_take   = wr_ack_i && outstanding_q;
    wr_req_o   = pop;
    wr_addr_o  = pop ? cur_addr_q : '0;
    wr_data_o  = pop ? mem_q[rd_ptr_q] : '0;
    busy_o     = (state_q == RUN) || (state_q == DONE);
    done_o     = (state_q == DONE) || zero_done_q;
    level_o    = level_q;
    state_o    = state_q;
  end

  // State register and the zero-length done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= start_zero;
    end
  end

  // Transfer counters, destination address and outstanding-write flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q         <= '0;
      push_cnt_q    <= '0;
      ack_cnt_q     <= '0;
      cur_addr_q    <= '0;
      outstanding_q <= 1'b0;
    end else if (start_go) begin
      len_q         <= len_i;
      push_cnt_q    <= '0;
      ack_cnt_q     <= '0;
      cur_addr_q    <= dst_addr_i;
      outstanding_q <= 1'b0;
    end else begin
      if (push) push_cnt_q <= push_cnt_q + 16'd1;
      if (pop) begin
        outstanding_q <= 1'b1;
      end else if (ack_take) begin
        outstanding_q <= 1'b0;
        ack_cnt_q     <= ack_cnt_q + 16'd1;
        cur_addr_q    <= cur_addr_q + STEP;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle keep the level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (start_go) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care while the level says empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rd_data_i;
  end

endmodule

// File: tb/tb_ndma_wr_feeder.sv
// Testbench for ndma_wr_feeder: randomized read-side traffic and write-manager
// ack latencies, checked against an address/data list computed from the
// transfer parameters and against occupancy/handshake rules.
module tb_ndma_wr_feeder;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   start = 1'b0;
  logic [AW-1:0]          dst_addr = '0;
  logic [15:0]            len = '0;
  logic                   busy, done;
  logic                   rd_valid = 1'b0;
  logic [DW-1:0]          rd_data = '0;
  logic                   rd_ready;
  logic                   wr_req;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   wr_ack = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic [1:0]             state_dbg;

  // Clock
  always #5 clk = ~clk;

  ndma_wr_feeder #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dst_addr_i(dst_addr), .len_i(len),
    .busy_o(busy), .done_o(done), .rd_valid_i(rd_valid), .rd_data_i(rd_data),
    .rd_ready_o(rd_ready), .wr_req_o(wr_req), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .wr_ack_i(wr_ack), .level_o(level), .state_o(state_dbg)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Scoreboard: expected {addr,data} per write, and what the DUT produced.
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];
  logic [DW-1:0]    src_q[$];
  int               req_cyc_q[$];

  int accepted, issued, done_cnt, done_cyc, last_ack_cyc, timed_out;
  int lvl_err, rdy_err, proto_err, zero_err, busy_err;
  int snap_level, snap_ready, snap_reqs, snap_acc, snap_busy, snap_req, snap_done, snap_zero;

  // Reference: write i goes to dst + i*(DW/8) (mod 2^AW) carrying source word i.
  function automatic void build_expected(input logic [AW-1:0] dst, input int n);
    logic [AW-1:0] a;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = dst + AW'(i * (DW / 8));
      exp_q.push_back({a, src_q[i]});
    end
  endfunction

  // Driver: runs one transfer and records what the DUT does. The manager model
  // answers each request after lat_min..lat_max cycles, never before ack_hold.
  task automatic drive_transfer(input logic [AW-1:0] dst, input int n, input int lat_min,
                                input int lat_max, input int valid_pct, input int extra,
                                input int ack_hold, input int mid_start, input int rst_cyc,
                                input int snap_cyc);
    int  cyc, ack_at, lvl_model;
    bit  model_out, was_out, stop, exp_busy;
    obs_q.delete(); req_cyc_q.delete(); src_q.delete();
    for (int i = 0; i < n + extra; i++) src_q.push_back($urandom);
    accepted = 0; issued = 0; done_cnt = 0; done_cyc = -1; last_ack_cyc = -1; timed_out = 0;
    lvl_err = 0; rdy_err = 0; proto_err = 0; zero_err = 0; busy_err = 0;
    ack_at = -1; model_out = 0; cyc = 0; stop = 0;
    while (!stop) begin
      @(posedge clk); #1;
      start = (cyc == 0) || (cyc == mid_start);
      if (cyc == 0) begin
        dst_addr = dst;
        len = 16'(n);
      end else begin
        dst_addr = $urandom;
        len = 16'($urandom);
      end
      rd_valid = (accepted < n + extra) && (int'($urandom_range(99, 0)) < valid_pct);
      rd_data  = (accepted < n + extra) ? src_q[accepted] : $urandom;
      wr_ack   = (cyc == ack_at);
      if (cyc == rst_cyc) rst = 1'b1;
      @(negedge clk);
      lvl_model = accepted - issued;
      if (cyc == snap_cyc) begin
        snap_level = int'(level); snap_ready = int'(rd_ready); snap_reqs = issued;
        snap_acc = accepted; snap_busy = int'(busy); snap_req = int'(wr_req);
        snap_done = int'(done); snap_zero = int'(wr_addr == '0 && wr_data == '0);
      end
      if (cyc == rst_cyc) begin
        stop = 1;
      end else begin
        if (int'(level) != lvl_model) lvl_err++;
        if (rd_ready && (lvl_model >= DEPTH || accepted >= n)) rdy_err++;
        was_out = model_out;
        if (wr_ack && model_out) begin
          model_out = 0;
          last_ack_cyc = cyc;
        end
        if (wr_req) begin
          if (was_out || wr_ack || lvl_model == 0) proto_err++;
          obs_q.push_back({wr_addr, wr_data});
          req_cyc_q.push_back(cyc);
          issued++;
          model_out = 1;
          ack_at = cyc + int'($urandom_range(lat_max, lat_min));
          if (ack_at < ack_hold) ack_at = ack_hold;
        end else if (wr_addr != '0 || wr_data != '0) begin
          zero_err++;
        end
        if (rd_valid && rd_ready) accepted++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        exp_busy = (n != 0) && (cyc >= 1) && (done_cnt == 0 || cyc == done_cyc);
        if (busy !== exp_busy) busy_err++;
        cyc++;
        if (done_cnt > 0 && cyc > done_cyc + 2) stop = 1;
        if (cyc > 2000) begin
          timed_out = 1;
          stop = 1;
        end
      end
    end
    start = 1'b0; rd_valid = 1'b0; wr_ack = 1'b0;
    if (rst) begin
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; rd_valid = 1'b1; rd_data = $urandom; wr_ack = 1'b1;
    len = 16'd5; dst_addr = 32'h1234_5678;
    @(negedge clk);
    tests_run++;
    if ({busy, done, rd_ready, wr_req} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: busy/done/ready/req=%b%b%b%b expected 0000", busy, done, rd_ready, wr_req);
    end
    tests_run++;
    if (level !== '0) begin
      tests_failed++;
      $display("FAIL reset_level: got %0d expected 0", level);
    end
    tests_run++;
    if (wr_addr !== '0 || wr_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr=%h data=%h expected 0", wr_addr, wr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; rd_valid = 1'b0; wr_ack = 1'b0;
  endtask

  task automatic test_basic();
    drive_transfer(32'h0000_1000, 3, 2, 2, 100, 0, 0, -1, -1, -1);
    build_expected(32'h0000_1000, 3);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL basic_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL basic_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (req_cyc_q.size() == 0 || req_cyc_q[0] != 2) begin
      tests_failed++;
      $display("FAIL basic_first_req: got cycle %0d expected 2", req_cyc_q.size() ? req_cyc_q[0] : -1);
    end
    for (int i = 1; i < req_cyc_q.size(); i++) begin
      tests_run++;
      if (req_cyc_q[i] - req_cyc_q[i-1] != 3) begin
        tests_failed++;
        $display("FAIL basic_spacing%0d: got %0d expected 3", i, req_cyc_q[i] - req_cyc_q[i-1]);
      end
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != 11 || done_cyc != last_ack_cyc + 1) begin
      tests_failed++;
      $display("FAIL basic_done: count=%0d cycle=%0d last_ack=%0d expected 1 pulse at 11", done_cnt, done_cyc, last_ack_cyc);
    end
    tests_run++;
    if (lvl_err + rdy_err + proto_err + zero_err + busy_err + timed_out != 0) begin
      tests_failed++;
      $display("FAIL basic_rules: lvl=%0d rdy=%0d proto=%0d zero=%0d busy=%0d tmo=%0d expected all 0",
               lvl_err, rdy_err, proto_err, zero_err, busy_err, timed_out);
    end
  endtask

  task automatic test_backpressure();
    drive_transfer(32'h0000_2000, 8, 1, 3, 100, 0, 12, -1, -1, 11);
    build_expected(32'h0000_2000, 8);
    tests_run++;
    if (snap_level != DEPTH || snap_ready != 0 || snap_reqs != 1 || snap_acc != DEPTH + 1) begin
      tests_failed++;
      $display("FAIL bp_stall: level=%0d ready=%0d reqs=%0d accepted=%0d expected %0d/0/1/%0d",
               snap_level, snap_ready, snap_reqs, snap_acc, DEPTH, DEPTH + 1);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL bp_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL bp_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (lvl_err + rdy_err + proto_err + zero_err + busy_err + timed_out != 0 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL bp_rules: lvl=%0d rdy=%0d proto=%0d zero=%0d busy=%0d tmo=%0d done=%0d expected 0s and 1 done",
               lvl_err, rdy_err, proto_err, zero_err, busy_err, timed_out, done_cnt);
    end
  endtask

  task automatic test_wrap();
    drive_transfer(32'hFFFF_FFFC, 2, 1, 2, 100, 0, 0, -1, -1, -1);
    build_expected(32'hFFFF_FFFC, 2);
    tests_run++;
    if (obs_q.size() != 2) begin
      tests_failed++;
      $display("FAIL wrap_nwrites: got %0d expected 2", obs_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL wrap_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_len_zero();
    drive_transfer(32'h0000_3000, 0, 1, 1, 100, 3, 0, -1, -1, -1);
    tests_run++;
    if (done_cnt != 1 || done_cyc != 1) begin
      tests_failed++;
      $display("FAIL zero_done: count=%0d cycle=%0d expected 1 pulse at 1", done_cnt, done_cyc);
    end
    tests_run++;
    if (obs_q.size() != 0 || accepted != 0 || busy_err != 0 || rdy_err != 0) begin
      tests_failed++;
      $display("FAIL zero_quiet: writes=%0d accepted=%0d busy_err=%0d rdy_err=%0d expected 0",
               obs_q.size(), accepted, busy_err, rdy_err);
    end
  endtask

  task automatic test_back_to_back();
    drive_transfer(32'h0000_4000, 10, 1, 1, 100, 2, 0, -1, -1, -1);
    build_expected(32'h0000_4000, 10);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL b2b_nwrites: got %0d expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL b2b_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    for (int i = 1; i < req_cyc_q.size(); i++) begin
      tests_run++;
      if (req_cyc_q[i] - req_cyc_q[i-1] != 2) begin
        tests_failed++;
        $display("FAIL b2b_spacing%0d: got %0d expected 2", i, req_cyc_q[i] - req_cyc_q[i-1]);
      end
    end
    tests_run++;
    if (accepted != 10 || rdy_err != 0) begin
      tests_failed++;
      $display("FAIL b2b_overrun: accepted=%0d rdy_err=%0d expected 10/0", accepted, rdy_err);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] dst;
    int n;
    for (int it = 0; it < 8; it++) begin
      dst = $urandom & 32'hFFFF_FFFC;
      n = int'($urandom_range(12, 1));
      drive_transfer(dst, n, int'($urandom_range(2, 1)), int'($urandom_range(5, 2)),
                     int'($urandom_range(100, 30)), int'($urandom_range(3, 0)), 0, -1, -1, -1);
      build_expected(dst, n);
      tests_run++;
      if (obs_q != exp_q) begin
        tests_failed++;
        $display("FAIL rand%0d_writes: got %0d writes, expected %0d matching writes", it, obs_q.size(), exp_q.size());
      end
      tests_run++;
      if (accepted != n || done_cnt != 1 || done_cyc != last_ack_cyc + 1) begin
        tests_failed++;
        $display("FAIL rand%0d_count: accepted=%0d done=%0d@%0d last_ack=%0d expected %0d/1/ack+1",
                 it, accepted, done_cnt, done_cyc, last_ack_cyc, n);
      end
      tests_run++;
      if (lvl_err + rdy_err + proto_err + zero_err + busy_err + timed_out != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_rules: lvl=%0d rdy=%0d proto=%0d zero=%0d busy=%0d tmo=%0d expected all 0",
                 it, lvl_err, rdy_err, proto_err, zero_err, busy_err, timed_out);
      end
    end
  endtask

  task automatic test_spurious_and_reset();
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      wr_ack = 1'b1;
      @(negedge clk);
      if (wr_req || busy || done || level != '0) bad++;
    end
    @(posedge clk); #1;
    wr_ack = 1'b0;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL spurious_idle: %0d disturbed cycles expected 0", bad);
    end
    drive_transfer(32'h0000_5000, 5, 2, 3, 70, 2, 0, 3, -1, -1);
    build_expected(32'h0000_5000, 5);
    tests_run++;
    if (obs_q != exp_q || done_cnt != 1 || accepted != 5) begin
      tests_failed++;
      $display("FAIL restart_ignored: writes=%0d done=%0d accepted=%0d expected 5 matching/1/5",
               obs_q.size(), done_cnt, accepted);
    end
    drive_transfer(32'h0000_6000, 6, 3, 3, 100, 0, 0, -1, 4, 4);
    tests_run++;
    if (snap_level != 0 || snap_busy != 0 || snap_req != 0 || snap_ready != 0 || snap_done != 0 || snap_zero != 1) begin
      tests_failed++;
      $display("FAIL midreset_clear: level=%0d busy=%0d req=%0d ready=%0d done=%0d zero=%0d expected 0/0/0/0/0/1",
               snap_level, snap_busy, snap_req, snap_ready, snap_done, snap_zero);
    end
    drive_transfer(32'h0000_7000, 3, 1, 2, 100, 0, 0, -1, -1, -1);
    build_expected(32'h0000_7000, 3);
    tests_run++;
    if (obs_q != exp_q || done_cnt != 1 || req_cyc_q.size() == 0 || req_cyc_q[0] != 2) begin
      tests_failed++;
      $display("FAIL after_reset: writes=%0d done=%0d first_req=%0d expected 3 matching/1/2",
               obs_q.size(), done_cnt, req_cyc_q.size() ? req_cyc_q[0] : -1);
    end
    tests_run++;
    if (lvl_err + rdy_err + proto_err + zero_err + busy_err + timed_out != 0) begin
      tests_failed++;
      $display("FAIL after_reset_rules: lvl=%0d rdy=%0d proto=%0d zero=%0d busy=%0d tmo=%0d expected all 0",
               lvl_err, rdy_err, proto_err, zero_err, busy_err, timed_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_len_zero();
    test_back_to_back();
    test_random();
    test_spurious_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
